// File: rtl/smips_pkg.sv
// Shared SMIPS core constants and register-index type.
package smips_pkg;

  localparam int unsigned SMIPS_XLEN     = 32;
  localparam int unsigned SMIPS_NREGS    = 32;
  localparam int unsigned SMIPS_REG_ZERO = 0;

  typedef logic [4:0] reg_idx_t;

endpackage : smips_pkg

// File: rtl/rf_read_port.sv
// One synchronous register-file read port: zero-index masking, write bypass
// priority mux and enable-hold output register.
module rf_read_port
  import smips_pkg::*;
#(
  parameter int unsigned DATA_W   = SMIPS_XLEN,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] rd_data_nxt_c;

  // Port B is checked last so it wins when both writes hit the read index.
  always_comb begin
    rd_data_nxt_c = arr_data;
    if (BYPASS != 0) begin
      if (wa_en && (wa_addr == rd_addr)) rd_data_nxt_c = wa_data;
      if (wb_en && (wb_addr == rd_addr)) rd_data_nxt_c = wb_data;
    end
    if ((ZERO_REG != 0) && (rd_addr == ADDR_W'(SMIPS_REG_ZERO))) begin
      rd_data_nxt_c = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_data_nxt_c;
    end
  end

endmodule : rf_read_port

// File: rtl/multiport_register_file.sv
// NUM_RD-read / 2-write register file with async clear, optional zero register
// and optional same-cycle write-to-read bypass.
module multiport_register_file
  import smips_pkg::*;
#(
  parameter int unsigned  DATA_W   = SMIPS_XLEN,
  parameter int unsigned  DEPTH    = SMIPS_NREGS,
  parameter int unsigned  NUM_RD   = 2,
  parameter int unsigned  ZERO_REG = 1,
  parameter int unsigned  BYPASS   = 1,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     wr_conflict
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wa_wr_c;
  logic              wb_wr_c;

  // Writes to the hard-wired zero index are dropped before they reach storage.
  always_comb begin
    wa_wr_c = wa_en;
    wb_wr_c = wb_en;
    if (ZERO_REG != 0) begin
      if (wa_addr == ADDR_W'(SMIPS_REG_ZERO)) wa_wr_c = 1'b0;
      if (wb_addr == ADDR_W'(SMIPS_REG_ZERO)) wb_wr_c = 1'b0;
    end
  end

  // Port B is written after port A so it wins a same-index double write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wa_wr_c) mem[wa_addr] <= wa_data;
      if (wb_wr_c) mem[wb_addr] <= wb_data;
    end
  end

  // Conflict reflects raw enables, so a double write to index 0 still flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= wa_en && wb_en && (wa_addr == wb_addr);
    end
  end

  for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_port (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_en    (rd_en[i]),
      .rd_addr  (rd_addr[i*ADDR_W +: ADDR_W]),
      .arr_data (mem[rd_addr[i*ADDR_W +: ADDR_W]]),
      .wa_en    (wa_wr_c),
      .wa_addr  (wa_addr),
      .wa_data  (wa_data),
      .wb_en    (wb_wr_c),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .rd_data  (rd_data[i*DATA_W +: DATA_W])
    );
  end

endmodule : multiport_register_file

// File: tb/tb_multiport_register_file.sv
// Directed scoreboard bench: one default instance (bypass, zero reg) and one
// read-before-write instance without zero reg, driven with identical stimulus.
module tb_multiport_register_file;
  import smips_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    rd_en;
  logic [2*AW-1:0] rd_addr;
  logic          wa_en, wb_en;
  reg_idx_t      wa_addr, wb_addr;
  logic [DW-1:0] wa_data, wb_data;
  logic [2*DW-1:0] rd_data_a, rd_data_b;
  logic          conf_a, conf_b;

  multiport_register_file dut_a (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wr_conflict(conf_a)
  );

  multiport_register_file #(.ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wr_conflict(conf_b)
  );

  always #5 clk = ~clk;

  // sel: 0/1 = dut_a port0/1, 2/3 = dut_b port0/1, 4 = dut_a conflict, 5 = dut_b conflict
  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      0:       return rd_data_a[0  +: DW];
      1:       return rd_data_a[DW +: DW];
      2:       return rd_data_b[0  +: DW];
      3:       return rd_data_b[DW +: DW];
      4:       return 32'(conf_a);
      default: return 32'(conf_b);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    exp_q.push_back(e);
  endtask

  // Advance one edge, then compare everything expected from that edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic idle();
    rd_en = 2'b00;
    wa_en = 1'b0;
    wb_en = 1'b0;
  endtask

  task automatic set_rd(input logic [1:0] en, input reg_idx_t a0, input reg_idx_t a1);
    rd_en   = en;
    rd_addr = {a1, a0};
  endtask

  task automatic set_wa(input reg_idx_t a, input logic [31:0] d);
    wa_en = 1'b1; wa_addr = a; wa_data = d;
  endtask

  task automatic set_wb(input reg_idx_t a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    rd_addr = '0; wa_addr = '0; wb_addr = '0; wa_data = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd_a", rd_data_a[31:0], 32'h0);
    check("reset_rd_b", rd_data_b[63:32], 32'h0);
    check("reset_conf", 32'(conf_a), 32'h0);
    rst_n = 1'b1;

    // Reset clears array and outputs immediately
    set_wa(5'd5, 32'hDEADBEEF); tick();
    idle(); set_rd(2'b11, 5'd5, 5'd5);
    push("pre_reset_a", 0, 32'hDEADBEEF); push("pre_reset_b", 2, 32'hDEADBEEF);
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    check("async_clr_a", rd_data_a[31:0], 32'h0);
    check("async_clr_b", rd_data_b[31:0], 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_rd(2'b11, 5'd5, 5'd5);
    push("post_reset_a", 0, 32'h0); push("post_reset_b", 2, 32'h0);
    tick();

    // Basic write then read on both ports
    idle(); set_wa(5'd3, 32'h12345678); tick();
    idle(); set_rd(2'b11, 5'd3, 5'd3);
    push("basic_a0", 0, 32'h12345678); push("basic_a1", 1, 32'h12345678);
    push("basic_b0", 2, 32'h12345678); push("basic_b1", 3, 32'h12345678);
    tick();

    // Same-edge write and read: bypass vs read-before-write
    idle(); set_wa(5'd7, 32'h1); tick();
    idle(); set_wa(5'd7, 32'hA5A5A5A5); set_rd(2'b01, 5'd7, 5'd3);
    push("bypass_a", 0, 32'hA5A5A5A5); push("rbw_b", 2, 32'h1);
    tick();
    idle(); set_rd(2'b01, 5'd7, 5'd3);
    push("rbw_next_a", 0, 32'hA5A5A5A5); push("rbw_next_b", 2, 32'hA5A5A5A5);
    tick();

    // Same-index double write: port B wins, conflict flag for one cycle
    idle(); set_wa(5'd9, 32'h1111); set_wb(5'd9, 32'h2222); set_rd(2'b01, 5'd9, 5'd3);
    push("conf_byp_a", 0, 32'h2222); push("conf_rbw_b", 2, 32'h0);
    push("conf_flag_a", 4, 32'h1); push("conf_flag_b", 5, 32'h1);
    tick();
    idle(); set_wa(5'd10, 32'hA); set_wb(5'd11, 32'hB); set_rd(2'b01, 5'd9, 5'd3);
    push("conf_rd_a", 0, 32'h2222); push("conf_rd_b", 2, 32'h2222);
    push("noconf_a", 4, 32'h0); push("noconf_b", 5, 32'h0);
    tick();
    idle(); set_rd(2'b11, 5'd10, 5'd11);
    push("dual_wa_a", 0, 32'hA); push("dual_wb_a", 1, 32'hB);
    push("dual_wa_b", 2, 32'hA); push("dual_wb_b", 3, 32'hB);
    push("conf_clr_a", 4, 32'h0);
    tick();

    // Zero register: writes discarded and not bypassed; conflict still flagged
    idle(); set_wa(5'd0, 32'hFFFFFFFF); set_wb(5'd0, 32'h77); set_rd(2'b01, 5'd0, 5'd3);
    push("zero_byp_a", 0, 32'h0); push("zero_rbw_b", 2, 32'h0);
    push("zero_conf_a", 4, 32'h1); push("zero_conf_b", 5, 32'h1);
    tick();
    idle(); set_wa(5'd0, 32'hFFFFFFFF); set_rd(2'b01, 5'd0, 5'd3);
    push("zero_rd_a", 0, 32'h0); push("zero_rd_b", 2, 32'h77);
    tick();
    idle(); set_rd(2'b01, 5'd0, 5'd3);
    push("zero_rd2_a", 0, 32'h0); push("zero_rd2_b", 2, 32'hFFFFFFFF);
    tick();

    // Read hold on port1 across a rewrite of the held index
    idle(); set_wa(5'd4, 32'h55); tick();
    idle(); set_rd(2'b10, 5'd3, 5'd4);
    push("hold_ld_a", 1, 32'h55); push("hold_ld_b", 3, 32'h55);
    tick();
    idle(); set_wa(5'd4, 32'h66); set_rd(2'b00, 5'd3, 5'd3);
    push("hold1_a", 1, 32'h55); push("hold1_b", 3, 32'h55);
    tick();
    idle(); set_rd(2'b00, 5'd3, 5'd3);
    push("hold2_a", 1, 32'h55); push("hold2_b", 3, 32'h55);
    tick();
    idle(); set_rd(2'b11, 5'd4, 5'd3);
    push("unhold_a1", 1, 32'h12345678); push("unhold_b1", 3, 32'h12345678);
    push("rewrite_a0", 0, 32'h66); push("rewrite_b0", 2, 32'h66);
    tick();

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_multiport_register_file

// File: doc/multiport_register_file.md
Name: multiport_register_file

Overview:
Parametrised successor to the core's 2-read/1-write register file. Provides NUM_RD synchronous read ports and two write ports, with the following features:
- asynchronous clear
- optional hard-wired zero register
- per-port read enable (hold on stall)
- optional write-to-read bypass

It sits between decode and execute in the SMIPS pipeline. A second write port serves the load/long-latency writeback path.

Parameters:
DATA_W, 32, register width in bits
DEPTH, 32, number of registers (power of two, >= 2)
ADDR_W, $clog2(DEPTH), register index width (derived, not overridden)
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = read-before-write

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
rd_en  in  NUM_RD  per-port read enable; 0 holds that port's output
rd_addr  in  NUM_RD*ADDR_W  read indices, port i at [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  registered read data, port i at [i*DATA_W +: DATA_W]
wa_en  in  1  write port A enable (ALU writeback)
wa_addr  in  ADDR_W  write port A index
wa_data  in  DATA_W  write port A data
wb_en  in  1  write port B enable (load writeback)
wb_addr  in  ADDR_W  write port B index
wb_data  in  DATA_W  write port B data
wr_conflict  out  1  registered flag: previous cycle had both writes to the same index

Behaviour:
- Interface: one clock clk; asynchronous, active-low reset rst_n.
- Reset (rst_n=0, asynchronous):
  - all DEPTH entries cleared to 0;
  - rd_data cleared to 0;
  - wr_conflict cleared to 0.
  - Release is synchronous to clk; the first edge after release performs normal operation.
  - Reset mid-write: the write is lost and the entry reads 0.
- Read latency is 1 cycle. On a clk edge with rd_en[i]=1, rd_data[i] loads the value for rd_addr[i]. With rd_en[i]=0, rd_data[i] holds its value, including across writes to the held index.
- Write: on a clk edge, each enabled port stores its data at its index.
- Same-index double write (wa_en & wb_en & wa_addr==wb_addr): port B wins and wr_conflict=1 on the next cycle. Otherwise wr_conflict=0 on the next cycle.
- BYPASS=1: if rd_en[i] and rd_addr[i] matches an enabled write index in the same edge, rd_data[i] takes that write's data. If both write ports match, port B's data is used. The array read is used only when nothing matches.
- BYPASS=0: reads return the pre-edge array contents (read-before-write).
- ZERO_REG=1:
  - writes to index 0 are discarded and never bypassed;
  - reads of index 0 return 0;
  - a same-index conflict on index 0 still raises wr_conflict.
- ZERO_REG=0: index 0 is an ordinary register.
- Index width equals ADDR_W exactly, so no out-of-range check is required.
- All read ports are independent. Any number of ports may read the same index in one cycle.

Decomposition:
- Shared package smips_pkg holds:
  - SMIPS_XLEN=32;
  - SMIPS_NREGS=32;
  - SMIPS_REG_ZERO=0;
  - the reg_idx_t typedef (logic [4:0]).
- One natural sub-module is rf_read_port. It is instantiated NUM_RD times via generate. Each instance performs index-0 masking, the bypass compare/priority mux and the enable-hold output register for one port.
- The storage array and write logic stay in the top module.

Test Plan:
All scenarios use default parameters unless stated.
- Reset: write 0xDEADBEEF to r5, assert rst_n=0 between edges, then release and read r5 -> rd_data becomes 0 immediately on assertion; the r5 read returns 0x00000000 one cycle after release.
- Basic write/read: wa writes r3=0x12345678; the next cycle reads port0=r3 and port1=r3 -> both ports show 0x12345678 one cycle later.
- Bypass and read-before-write:
  - BYPASS=1: a write to r7=0xA5A5A5A5 in the same edge as a read of r7 (old value 0x1) -> rd_data=0xA5A5A5A5.
  - BYPASS=0: same stimulus -> rd_data=0x00000001, and 0xA5A5A5A5 appears on the next read.
- Write conflict: wa r9=0x1111 and wb r9=0x2222 on the same edge -> wr_conflict=1 for one cycle; a later read of r9 returns 0x2222. Same-edge bypassed read of r9 returns 0x2222.
- Zero register:
  - ZERO_REG=1: wa writes r0=0xFFFFFFFF with a same-edge read of r0 -> read returns 0; a later read also returns 0.
  - ZERO_REG=0: a later read returns 0xFFFFFFFF.
- Read hold: port1 reads r4=0x55, then rd_en[1]=0 while r4 is rewritten to 0x66 and rd_addr[1] changes -> rd_data[1] stays 0x55 until rd_en[1]=1, then shows the new index's value.
